// File: rtl/gmii_tx_framer.sv
// gmii_tx_framer: per-port GMII transmit framer.
// Takes the crossbar's unthrottled byte stream and emits preamble/SFD, the
// payload delayed through an 8-entry line, the CRC-32 FCS and the IFG.
// Optional build macro: TX_PAD_EN pads runt payloads with 0x00 up to
// P_MIN_FRAME bytes before the FCS.
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   tx_data_i, tx_ctrl_i    crossbar byte and frame-valid
//   gmii_txd_o/tx_en_o/tx_er_o  GMII transmit interface (tx_er held 0)
//   drop_o                  one-cycle pulse per dropped incoming frame
//   frame_cnt_o, drop_cnt_o wrapping statistics counters
module gmii_tx_framer #(
  parameter int unsigned P_IFG_BYTES = 12,
  parameter int unsigned P_MIN_FRAME = 60,
  parameter int unsigned P_CNT_WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [7:0]             tx_data_i,
  input  logic                   tx_ctrl_i,
  output logic [7:0]             gmii_txd_o,
  output logic                   gmii_tx_en_o,
  output logic                   gmii_tx_er_o,
  output logic                   drop_o,
  output logic [P_CNT_WIDTH-1:0] frame_cnt_o,
  output logic [P_CNT_WIDTH-1:0] drop_cnt_o
);

  localparam int unsigned DLY_DEPTH = 8;
  localparam int unsigned CNT_W     = (P_IFG_BYTES > 8) ? $clog2(P_IFG_BYTES) : 3;
  localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(P_IFG_BYTES - 1);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(7);
  localparam logic [CNT_W-1:0] SFD_CNT  = CNT_W'(6);
  localparam logic [CNT_W-1:0] FCS_LAST = CNT_W'(3);
  localparam logic [31:0] CRC_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_DATA,
    S_FCS,
    S_IFG
  } state_e;

  state_e state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [31:0]                  crc_q, crc_d;
  logic [DLY_DEPTH-1:0][8:0]    line_q, line_d;   // {valid, data}; [0] head, [7] tail
  logic                         ctrl_prev_q, ctrl_prev_d;
  logic                         drop_act_q, drop_act_d;
  logic [7:0]                   txd_q, txd_d;
  logic                         tx_en_q, tx_en_d;
  logic                         tx_er_q;
  logic                         drop_q, drop_d;
  logic [P_CNT_WIDTH-1:0]       frame_cnt_q, frame_cnt_d;
  logic [P_CNT_WIDTH-1:0]       drop_cnt_q, drop_cnt_d;
`ifdef TX_PAD_EN
  logic [10:0]                  byte_cnt_q, byte_cnt_d;
`endif

  logic       rise;
  logic       accept;
  logic       emit;
  logic       more;
  logic [7:0] out_byte;
  logic [31:0] fcs;
  logic [1:0] fcs_idx;

  // One reflected CRC-32 step over a byte, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    crc_d       = crc_q;
    txd_d       = 8'h00;
    tx_en_d     = 1'b0;
    drop_d      = 1'b0;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    ctrl_prev_d = tx_ctrl_i;
    rise        = tx_ctrl_i & ~ctrl_prev_q;
    accept      = 1'b0;
    emit        = 1'b0;
    fcs         = ~crc_q;
    fcs_idx     = 2'(cnt_q + CNT_W'(1));
    out_byte    = line_q[DLY_DEPTH-1][7:0];
    more        = line_q[DLY_DEPTH-1][8];
`ifdef TX_PAD_EN
    byte_cnt_d  = byte_cnt_q;
    // Past the end of the payload, keep sending zeros until the minimum size.
    if (!more) out_byte = 8'h00;
    more = more | (byte_cnt_q < 11'(P_MIN_FRAME));
`endif

    case (state_q)
      S_IDLE: accept = rise;
      S_PRE: begin
        if (cnt_q == PRE_LAST) begin
          emit = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          tx_en_d = 1'b1;
          txd_d   = (cnt_q == SFD_CNT) ? 8'hD5 : 8'h55;
        end
      end
      S_DATA: emit = 1'b1;
      S_FCS: begin
        if (cnt_q == FCS_LAST) begin
          state_d     = S_IFG;
          cnt_d       = '0;
          frame_cnt_d = frame_cnt_q + P_CNT_WIDTH'(1);
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          tx_en_d = 1'b1;
          txd_d   = 8'(fcs >> {fcs_idx, 3'b000});
        end
      end
      S_IFG: begin
        if (cnt_q == IFG_LAST) begin
          state_d = S_IDLE;
          accept  = rise;   // a rise on the exit cycle is taken, not dropped
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Emit one delay-line byte, or the first FCS byte once the payload ends.
    if (emit) begin
      tx_en_d = 1'b1;
      if (more) begin
        state_d = S_DATA;
        txd_d   = out_byte;
        crc_d   = crc32_byte(crc_q, out_byte);
`ifdef TX_PAD_EN
        if (byte_cnt_q != 11'h7FF) byte_cnt_d = byte_cnt_q + 11'd1;
`endif
      end else begin
        state_d = S_FCS;
        cnt_d   = '0;
        txd_d   = fcs[7:0];
      end
    end

    if (accept) begin
      state_d = S_PRE;
      cnt_d   = '0;
      tx_en_d = 1'b1;
      txd_d   = 8'h55;
      crc_d   = CRC_INIT;
`ifdef TX_PAD_EN
      byte_cnt_d = '0;
`endif
    end else if (rise) begin
      drop_d     = 1'b1;
      drop_cnt_d = drop_cnt_q + P_CNT_WIDTH'(1);
    end

    // A dropped frame stays masked (valid=0) until tx_ctrl_i falls.
    drop_act_d = (drop_act_q & tx_ctrl_i) | (rise & ~accept);
    line_d     = {line_q[DLY_DEPTH-2:0], {tx_ctrl_i & ~drop_act_d, tx_data_i}};
  end

  // State and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      crc_q       <= CRC_INIT;
      line_q      <= '0;
      ctrl_prev_q <= 1'b0;
      drop_act_q  <= 1'b0;
      txd_q       <= 8'h00;
      tx_en_q     <= 1'b0;
      tx_er_q     <= 1'b0;
      drop_q      <= 1'b0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
`ifdef TX_PAD_EN
      byte_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      crc_q       <= crc_d;
      line_q      <= line_d;
      ctrl_prev_q <= ctrl_prev_d;
      drop_act_q  <= drop_act_d;
      txd_q       <= txd_d;
      tx_en_q     <= tx_en_d;
      tx_er_q     <= 1'b0;
      drop_q      <= drop_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
`ifdef TX_PAD_EN
      byte_cnt_q  <= byte_cnt_d;
`endif
    end
  end

  assign gmii_txd_o   = txd_q;
  assign gmii_tx_en_o = tx_en_q;
  assign gmii_tx_er_o = tx_er_q;
  assign drop_o       = drop_q;
  assign frame_cnt_o  = frame_cnt_q;
  assign drop_cnt_o   = drop_cnt_q;

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Testbench for gmii_tx_framer: a frame-level timeline model predicts every
// output cycle from the input schedule; literal pins anchor the model.
module tb_gmii_tx_framer;

  localparam int IFG  = 12;
  localparam int MINF = 60;
  localparam int CW   = 4;
  localparam int MAXC = 16000;
  localparam int K_EN = 0, K_TXD = 1, K_DROP = 2, K_FCNT = 3, K_DCNT = 4;

  typedef logic [7:0] u8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    tx_data = 8'h00;
  logic          tx_ctrl = 1'b0;
  logic [7:0]    gmii_txd;
  logic          gmii_tx_en;
  logic          gmii_tx_er;
  logic          drop;
  logic [CW-1:0] frame_cnt;
  logic [CW-1:0] drop_cnt;

  always #4 clk = ~clk;

  gmii_tx_framer #(
    .P_IFG_BYTES(IFG),
    .P_MIN_FRAME(MINF),
    .P_CNT_WIDTH(CW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .tx_data_i   (tx_data),
    .tx_ctrl_i   (tx_ctrl),
    .gmii_txd_o  (gmii_txd),
    .gmii_tx_en_o(gmii_tx_en),
    .gmii_tx_er_o(gmii_tx_er),
    .drop_o      (drop),
    .frame_cnt_o (frame_cnt),
    .drop_cnt_o  (drop_cnt)
  );

  // Cycle-indexed schedule and expected timeline.
  bit in_ctrl [MAXC];
  u8  in_data [MAXC];
  bit rst_s   [MAXC];
  bit exp_en  [MAXC];
  u8  exp_txd [MAXC];
  bit exp_drop[MAXC];
  int finc    [MAXC];
  int dinc    [MAXC];

  int    pin_cyc[$];
  int    pin_kind[$];
  int    pin_val[$];
  string pin_name[$];

  int next_ok;   // earliest input cycle at which a rise is accepted
  int last_end;  // first low cycle after the most recent input frame
  int errors = 0;
  int checks = 0;

  // FCS value (already complemented) of a byte sequence.
  function automatic logic [31:0] sw_fcs(input u8 q[$]);
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      c = c ^ 32'(q[i]);
      repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic void pin(input int c, input int k, input int v, input string nm);
    pin_cyc.push_back(c);
    pin_kind.push_back(k);
    pin_val.push_back(v);
    pin_name.push_back(nm);
  endfunction

  // Schedule a frame starting at input cycle s and predict its effect.
  task automatic add_frame(input int s, input u8 fb[$], output int len_out);
    u8 pl[$];
    logic [31:0] fcs;
    int L;
    for (int i = 0; i < fb.size(); i++) begin
      in_ctrl[s+i] = 1'b1;
      in_data[s+i] = fb[i];
    end
    last_end = s + fb.size();
    len_out = 0;
    if (s >= next_ok) begin
      pl = fb;
`ifdef TX_PAD_EN
      while (pl.size() < MINF) pl.push_back(8'h00);
`endif
      L = pl.size();
      fcs = sw_fcs(pl);
      for (int k = 0; k < 8; k++) begin
        exp_en[s+1+k]  = 1'b1;
        exp_txd[s+1+k] = (k < 7) ? 8'h55 : 8'hD5;
      end
      for (int k = 0; k < L; k++) begin
        exp_en[s+9+k]  = 1'b1;
        exp_txd[s+9+k] = pl[k];
      end
      for (int k = 0; k < 4; k++) begin
        exp_en[s+9+L+k]  = 1'b1;
        exp_txd[s+9+L+k] = 8'(fcs >> (8*k));
      end
      finc[s+L+13] += 1;
      next_ok = s + L + 12 + IFG;
      len_out = L;
    end else begin
      exp_drop[s+1] = 1'b1;
      dinc[s+1] += 1;
    end
  endtask

  // Reset over input cycles r0..r1: everything predicted from r0 on is lost.
  task automatic do_reset(input int r0, input int r1);
    for (int c = r0; c < MAXC; c++) begin
      exp_en[c] = 1'b0; exp_txd[c] = 8'h00; exp_drop[c] = 1'b0;
      finc[c] = 0; dinc[c] = 0;
    end
    for (int c = r0; c <= r1; c++) rst_s[c] = 1'b1;
    next_ok = r1 + 1;
  endtask

  initial begin
    u8 fb[$];
    int s, s2, s3, s4, r0, r1, len, total, fc, dc, got;
    bit ok;

    // ---------------- build schedule ----------------
    for (int c = 0; c < 5; c++) rst_s[c] = 1'b1;
    next_ok = 5;
    last_end = 5;

    fb = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    checks++;
    if (sw_fcs(fb) !== 32'hCBF43926) begin
      errors++;
      $display("FAIL model_crc: got %08h want cbf43926", sw_fcs(fb));
    end
    s = 10;
    add_frame(s, fb, len);
    pin(s+1, K_EN, 1, "pre_en");
    pin(s+1, K_TXD, 8'h55, "pre0");
    pin(s+7, K_TXD, 8'h55, "pre6");
    pin(s+8, K_TXD, 8'hD5, "sfd");
    pin(s+9, K_TXD, 8'h31, "d0");
    pin(s+17, K_TXD, 8'h39, "d8");
`ifndef TX_PAD_EN
    pin(s+18, K_TXD, 8'h26, "fcs0");
    pin(s+19, K_TXD, 8'h39, "fcs1");
    pin(s+20, K_TXD, 8'hF4, "fcs2");
    pin(s+21, K_TXD, 8'hCB, "fcs3");
    pin(s+22, K_EN, 0, "ifg_first");
    pin(s+33, K_EN, 0, "ifg_last");
    pin(s+21, K_FCNT, 0, "fcnt_pre");
    pin(s+22, K_FCNT, 1, "fcnt_post");
`else
    pin(s+18, K_TXD, 8'h00, "pad0");
    pin(s+68, K_TXD, 8'h00, "pad_last");
    pin(s+72, K_EN, 1, "pad_fcs3");
    pin(s+73, K_EN, 0, "pad_ifg");
    pin(s+73, K_FCNT, 1, "fcnt_post");
`endif

    fb.delete();
    for (int i = 0; i < 64; i++) fb.push_back(8'hA0 + 8'(i % 16));
    s2 = next_ok;
    add_frame(s2, fb, len);
    pin(s2+1, K_EN, 1, "f64_en_first");
    pin(s2+9, K_TXD, 8'hA0, "f64_d0");
    pin(s2+76, K_EN, 1, "f64_en_last");
    pin(s2+77, K_EN, 0, "f64_ifg");
    s3 = last_end + 24;
    add_frame(s3, fb, len);
    pin(s2+88, K_EN, 0, "gap24_idle12");
    pin(s3+1, K_EN, 1, "gap24_accept");
    pin(s3+1, K_DCNT, 0, "gap24_nodrop");
    s4 = last_end + 20;
    add_frame(s4, fb, len);
    pin(s4, K_DROP, 0, "drop_before");
    pin(s4+1, K_DROP, 1, "drop_pulse");
    pin(s4+2, K_DROP, 0, "drop_single");
    pin(s4+1, K_DCNT, 1, "drop_cnt");
    pin(s4+9, K_EN, 0, "drop_no_en");
    pin(s4+40, K_EN, 0, "drop_no_en2");

    // Randomized frames around the acceptance boundary.
    for (int f = 0; f < 40; f++) begin
      fb.delete();
      len = $urandom_range(1, 100);
      for (int i = 0; i < len; i++) fb.push_back(8'($urandom));
      s = next_ok + $urandom_range(0, 12) - 6;
      if (s < last_end + 1) s = last_end + 1;
      add_frame(s, fb, len);
    end

    // Runt of 10 bytes.
    fb.delete();
    for (int i = 1; i <= 10; i++) fb.push_back(8'(i));
    s = next_ok + 3;
    add_frame(s, fb, len);
    pin(s+18, K_TXD, 8'h0A, "runt_d9");
`ifdef TX_PAD_EN
    pin(s+19, K_TXD, 8'h00, "runt_pad0");
    pin(s+68, K_TXD, 8'h00, "runt_pad49");
    pin(s+72, K_EN, 1, "runt_en72");
    pin(s+73, K_EN, 0, "runt_en_end");
`else
    pin(s+22, K_EN, 1, "runt_en14");
    pin(s+23, K_EN, 0, "runt_en_end");
`endif

    // Single-byte frame.
    fb = '{8'h5A};
    s = next_ok;
    add_frame(s, fb, len);
    pin(s+9, K_TXD, 8'h5A, "one_d0");
`ifndef TX_PAD_EN
    pin(s+13, K_EN, 1, "one_fcs3");
    pin(s+14, K_EN, 0, "one_end");
`endif

    // Reset during DATA byte 20 of a 100-byte frame.
    fb.delete();
    for (int i = 0; i < 100; i++) fb.push_back(8'($urandom));
    s = next_ok + 5;
    add_frame(s, fb, len);
    r0 = s + 9 + 20;
    r1 = r0 + 100;
    do_reset(r0, r1);
    pin(r0-1, K_EN, 1, "rst_before");
    pin(r0, K_EN, 0, "rst_same_cycle");
    pin(r0, K_FCNT, 0, "rst_fcnt");

    // After reset: 64-byte frame, then counter wrap.
    fb.delete();
    for (int i = 0; i < 64; i++) fb.push_back(8'hA0 + 8'(i % 16));
    s = r1 + 6;
    add_frame(s, fb, len);
    pin(s+9, K_TXD, 8'hA0, "post_d0");
    pin(s+72, K_TXD, 8'hAF, "post_d63");
    pin(s+77, K_FCNT, 1, "post_fcnt");
    for (int f = 0; f < 14; f++) begin
      fb.delete();
      len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++) fb.push_back(8'($urandom));
      add_frame(next_ok, fb, len);
    end
    pin(next_ok - IFG + 1, K_FCNT, 15, "fcnt_all_ones");
    fb = '{8'h11, 8'h22, 8'h33};
    add_frame(next_ok, fb, len);
    pin(next_ok - IFG, K_FCNT, 15, "fcnt_before_wrap");
    pin(next_ok - IFG + 1, K_FCNT, 0, "fcnt_wrap");
    pin(next_ok, K_DCNT, 0, "post_dcnt");
    total = next_ok + 30;

    if (total >= MAXC) begin
      $display("FAIL schedule_size: got %0d want below %0d", total, MAXC);
      $fatal(1, "schedule too long");
    end

    // ---------------- run and compare ----------------
    fc = 0;
    dc = 0;
    for (int c = 0; c < total; c++) begin
      @(negedge clk);
      rst     = rst_s[c];
      tx_ctrl = in_ctrl[c];
      tx_data = in_ctrl[c] ? in_data[c] : 8'($urandom);
      #1;
      if (rst_s[c]) begin
        fc = 0;
        dc = 0;
      end else begin
        fc = (fc + finc[c]) % (1 << CW);
        dc = (dc + dinc[c]) % (1 << CW);
      end
      checks++;
      ok = (gmii_tx_en === exp_en[c]) && (gmii_txd === exp_txd[c]) && (drop === exp_drop[c]) &&
           (gmii_tx_er === 1'b0) && (frame_cnt === CW'(fc)) && (drop_cnt === CW'(dc));
      if (!ok) begin
        errors++;
        $display("FAIL cycle %0d: got en=%b txd=%02h er=%b drop=%b fcnt=%0d dcnt=%0d want en=%b txd=%02h er=0 drop=%b fcnt=%0d dcnt=%0d",
                 c, gmii_tx_en, gmii_txd, gmii_tx_er, drop, frame_cnt, drop_cnt,
                 exp_en[c], exp_txd[c], exp_drop[c], fc, dc);
      end
      foreach (pin_cyc[i]) begin
        if (pin_cyc[i] == c) begin
          case (pin_kind[i])
            K_EN:    got = int'(gmii_tx_en);
            K_TXD:   got = int'(gmii_txd);
            K_DROP:  got = int'(drop);
            K_FCNT:  got = int'(frame_cnt);
            default: got = int'(drop_cnt);
          endcase
          checks++;
          if (got != pin_val[i]) begin
            errors++;
            $display("FAIL %s @%0d: got %0h want %0h", pin_name[i], c, got, pin_val[i]);
          end
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gmii_tx_framer.md
Name: gmii_tx_framer

Overview:
- Per-port transmit framer on the egress side of the crossbar; one instance per TX port.
- Consumes the crossbar's unthrottled byte stream (tx_data/tx_ctrl) and drives a GMII transmitter.
- Prepends preamble/SFD, appends the Ethernet FCS (CRC-32) and enforces the inter-frame gap.
- Uses a fixed 8-byte delay line; there is no backpressure toward the crossbar.

Parameters:
- P_IFG_BYTES, 12, idle cycles forced after the last FCS byte (minimum 1).
- P_MIN_FRAME, 60, minimum payload length before FCS; used only by TX_PAD_EN.
- P_CNT_WIDTH, 32, width of the statistics counters.

Ports:
- clk_i  input  1  125 MHz clock.
- rst_i  input  1  asynchronous active-high reset.
- tx_data_i  input  8  frame byte from the crossbar (DA first, no preamble, no FCS).
- tx_ctrl_i  input  1  high while tx_data_i is valid; contiguous for one frame; a falling edge ends the frame.
- gmii_txd_o  output  8  GMII transmit data.
- gmii_tx_en_o  output  1  GMII transmit enable.
- gmii_tx_er_o  output  1  GMII transmit error.
- drop_o  output  1  one-cycle pulse when an incoming frame is dropped.
- frame_cnt_o  output  P_CNT_WIDTH  frames transmitted; wraps.
- drop_cnt_o  output  P_CNT_WIDTH  frames dropped; wraps.

Behaviour:
- Reset (async assert, sync release): all outputs 0, state IDLE, delay line cleared, CRC register = 0xFFFFFFFF.
- All outputs are registered.
- Delay line: 8 entries of {valid, data}. It shifts every cycle, loading {tx_ctrl_i, tx_data_i} at the head.
- IDLE:
  - On tx_ctrl_i high, go to PREAMBLE with cnt=0.
  - The first preamble byte appears on gmii_txd_o on the next cycle.
- PREAMBLE (8 cycles):
  - gmii_tx_en_o=1.
  - cnt 0..6 drives 0x55; cnt 7 drives 0xD5.
  - Then go to DATA.
- DATA:
  - Output the delay-line tail byte; gmii_tx_en_o=1.
  - Update CRC with each output byte.
  - When the tail valid bit is 0 (end of frame), go to FCS without emitting that entry.
  - Input byte k appears on gmii_txd_o exactly 9 cycles after it is sampled.
- FCS (4 cycles):
  - Emit ~CRC, least-significant byte first.
  - CRC-32 parameters: reflected polynomial 0xEDB88320, init 0xFFFFFFFF, bytes processed LSB first.
- IFG:
  - gmii_tx_en_o=0 and gmii_txd_o=0x00 for P_IFG_BYTES cycles; then IDLE.
  - frame_cnt_o increments on entry to IFG.
- Overrun/drop:
  - A tx_ctrl_i rising edge seen in FCS or IFG cannot be absorbed, because the 8-entry line carries only the current frame.
  - The new frame is ignored until tx_ctrl_i falls; its entries are loaded with valid=0.
  - drop_o pulses on the rising edge; drop_cnt_o increments.
  - A rising edge in DATA is impossible without a preceding fall (that fall ends DATA), so it is the same case.
  - Required input gap between frames: at least 12 + P_IFG_BYTES cycles (24 by default).
- Frame of 1 byte: legal; output is 8 preamble + 1 data + 4 FCS bytes.
- Simultaneous tx_ctrl_i rise and IDLE exit from IFG in the same cycle: accepted (not dropped).
- gmii_tx_er_o: held 0; reserved.
- Counters saturate never; they wrap from all-ones to 0.
- Reset asserted mid-frame: outputs drop to 0 immediately and the partial frame is lost. No counter increments.

Optional Feature:
- Macro TX_PAD_EN.
- Defined:
  - If the payload ends with fewer than P_MIN_FRAME bytes, DATA continues emitting 0x00 (included in the CRC) until P_MIN_FRAME bytes have been sent, then goes to FCS.
  - The required input gap grows by the pad length.
  - A byte counter (11 bit, saturating at 2047) is added.
- Undefined: no padding, no byte counter; runts pass through as received.

Test Plan:
- Nine bytes ASCII "123456789", TX_PAD_EN undefined -> output 55x7, D5, 31..39, then FCS 26 39 F4 CB. Then 12 cycles with tx_en=0; frame_cnt_o=1.
- 64-byte frame 0xA0..0xAF repeating -> first data byte on gmii 9 cycles after first tx_ctrl_i sample. 76 consecutive tx_en cycles; FCS matches the bench's software CRC model.
- Two 64-byte frames with a 24-cycle gap -> both transmitted, exactly 12 idle cycles between them, drop_cnt_o=0. Repeat with a 20-cycle gap -> second frame dropped, drop_o single pulse, drop_cnt_o=1, no tx_en during it.
- TX_PAD_EN defined, 10-byte frame -> 10 data bytes plus 50 bytes 0x00, then FCS over 60 bytes; 72 tx_en cycles total.
- Reset asserted during DATA byte 20 of 100 -> gmii_tx_en_o=0 in the same cycle. After release, a new 64-byte frame is transmitted correctly; frame_cnt_o=1.
- Preload frame_cnt_o to all-ones via 2^P_CNT_WIDTH-1 frames (bench with P_CNT_WIDTH=4: 15 frames), then send one more -> counter reads 0.
